instr_fetch_stage: RTL and testbench

//  Instruction-fetch stage directly upstream of the control unit. Holds the PC and drives a

---
 rtl/instr_fetch_stage.sv | 98 +++++++++
 tb/tb_instr_fetch_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: PC register, synchronous imem address, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/bubble counters.
module instr_fetch_stage #(
   parameter int              INSTR_W  = 16,
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_target,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc,
   output logic [3:0]         opcode
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]        perf_fetched,
   output logic [15:0]        perf_bubbles
`endif
);

   typedef enum logic {BOOT, RUN} state_t;

   state_t          state_q, state_next;
   logic [PC_W-1:0] pc_q, pc_next;
   logic            load_bubble, advance;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_next  = RUN;
      pc_next     = pc_q + 1'b1;
      load_bubble = 1'b0;
      advance     = 1'b0;
      case (state_q)
         BOOT: begin
            pc_next     = RESET_PC;
            load_bubble = 1'b1;
         end
         RUN: begin
            if (redirect_valid) begin
               pc_next     = redirect_target;
               load_bubble = 1'b1;
            end else if (stall) begin
               pc_next = pc_q;
            end else begin
               advance = 1'b1;
            end
         end
         default: pc_next = RESET_PC;
      endcase
   end

   assign imem_addr = pc_next;

   // pc_q always tracks the address whose data is on imem_rdata this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         if_valid <= 1'b0;
         if_instr <= '0;
         if_pc    <= '0;
      end else begin
         state_q <= state_next;
         pc_q    <= pc_next;
         if (load_bubble) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
         end else if (advance) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= pc_q;
         end
      end
   end

   assign opcode = if_instr[INSTR_W-1 -: 4];

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_bubbles <= '0;
      end else begin
         if (advance && perf_fetched != 16'hFFFF)
            perf_fetched <= perf_fetched + 16'd1;
         if (load_bubble && perf_bubbles != 16'hFFFF)
            perf_bubbles <= perf_bubbles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a synchronous-read imem where mem[i] = {i, i}.
// Builds with or without FETCH_PERF_CNT_EN.
module tb_instr_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [7:0]  redirect_target;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata = '0;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [7:0]  if_pc;
   logic [3:0]  opcode;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] perf_fetched, perf_bubbles;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Synchronous-read memory: data for the address presented this cycle appears next cycle.
   always @(posedge clk) imem_rdata <= {imem_addr, imem_addr};

   instr_fetch_stage #(.INSTR_W(16), .PC_W(8), .RESET_PC(8'h00)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .if_valid        (if_valid),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .opcode          (opcode)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched    (perf_fetched),
      .perf_bubbles    (perf_bubbles)
`endif
   );

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_fetch(input string tag, input logic [7:0] pc);
      check({tag, " valid"}, {15'd0, if_valid}, 16'd1);
      check({tag, " pc"}, {8'd0, if_pc}, {8'd0, pc});
      check({tag, " instr"}, if_instr, {pc, pc});
      check({tag, " opcode"}, {12'd0, opcode}, {12'd0, pc[7:4]});
   endtask

   task automatic check_bubble(input string tag);
      check({tag, " valid"}, {15'd0, if_valid}, 16'd0);
      check({tag, " instr"}, if_instr, 16'h0000);
      check({tag, " opcode"}, {12'd0, opcode}, 16'd0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

      // Reset state
      tick(); tick();
      check_bubble("reset");
      check("reset if_pc", {8'd0, if_pc}, 16'h0000);
      check("reset imem_addr", {8'd0, imem_addr}, 16'h0000);

      // Free-run from reset: first valid instruction two edges after release
      rst = 1'b0;
      tick();
      check_bubble("boot");
      check("boot imem_addr", {8'd0, imem_addr}, 16'h0001);
      tick();
      check_fetch("first", 8'h00);
      check("first imem_addr", {8'd0, imem_addr}, 16'h0002);
`ifdef FETCH_PERF_CNT_EN
      check("perf fetched first", perf_fetched, 16'd1);
      check("perf bubbles first", perf_bubbles, 16'd1);
`endif
      for (int k = 1; k <= 5; k++) begin
         tick();
         check_fetch("run", 8'(k));
      end

      // Stall three cycles at if_pc=5
      stall = 1'b1;
      #1 check("stall imem_addr", {8'd0, imem_addr}, 16'h0006);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_fetch("stall hold", 8'h05);
         check("stall imem_addr hold", {8'd0, imem_addr}, 16'h0006);
      end
      stall = 1'b0;
      tick();
      check_fetch("stall release", 8'h06);

      // Redirect to 0x40
      redirect_valid = 1'b1; redirect_target = 8'h40;
      #1 check("redir imem_addr", {8'd0, imem_addr}, 16'h0040);
      tick();
      redirect_valid = 1'b0;
      check_bubble("redir bubble");
      #1 check("redir next addr", {8'd0, imem_addr}, 16'h0041);
      tick();
      check_fetch("redir target", 8'h40);
      tick();
      check_fetch("redir +1", 8'h41);

      // Redirect and stall together: redirect wins
      redirect_valid = 1'b1; redirect_target = 8'h80; stall = 1'b1;
      tick();
      redirect_valid = 1'b0; stall = 1'b0;
      check_bubble("redir+stall bubble");
      tick();
      check_fetch("redir+stall target", 8'h80);

      // PC wrap from 0xFF to 0x00
      redirect_valid = 1'b1; redirect_target = 8'hFE;
      tick();
      redirect_valid = 1'b0;
      check_bubble("wrap bubble");
      tick(); check_fetch("wrap FE", 8'hFE);
      tick(); check_fetch("wrap FF", 8'hFF);
      tick(); check_fetch("wrap 00", 8'h00);
`ifdef FETCH_PERF_CNT_EN
      check("perf bubbles pre-rst", perf_bubbles, 16'd4);
`endif

      // Mid-run reset at if_pc=9
      for (int k = 1; k <= 9; k++) tick();
      check_fetch("pre-rst", 8'h09);
      rst = 1'b1;
      tick();
      check_bubble("mid rst");
      check("mid rst imem_addr", {8'd0, imem_addr}, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
      check("perf fetched rst", perf_fetched, 16'd0);
      check("perf bubbles rst", perf_bubbles, 16'd0);
`endif
      rst = 1'b0;
      tick();
      check_bubble("restart boot");
      tick();
      check_fetch("restart first", 8'h00);
      tick();
      check_fetch("restart second", 8'h01);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
